// File: rtl/forget_gate_mac.sv
// Sequential MAC neuron: accumulates N_INPUTS x*w products onto a bias, then rounds and
// saturates to signed Q4.4 for the downstream sigmoid LUT/interpolator.
module forget_gate_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int ACC_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] z_value
);

  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int ZMAX_I = 2 ** (DATA_W - 1) - 1;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'(ZMAX_I);
  localparam logic signed [ACC_W-1:0] Z_MIN = ACC_W'(-ZMAX_I - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DATA_W-1:0]        z_q, z_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    bias_ext, prod_ext, rounded;
  logic [DATA_W-1:0]          sat_val;

  assign prod     = $signed(x_data) * $signed(w_data);
  assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // Round half up, then arithmetic shift back to Q4.4 scale.
  assign rounded  = (acc_q + HALF) >>> FRAC_W;

  always_comb begin
    if (rounded > Z_MAX)      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    else if (rounded < Z_MIN) sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    else                      sat_val = rounded[DATA_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    z_d       = z_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_INPUTS - 1)) state_d = ROUND;
        end
      end
      ROUND: begin
        z_d     = sat_val;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      z_q     <= z_d;
    end
  end

  assign z_value = z_q;

endmodule

// File: tb/tb_forget_gate_mac.sv
// Randomized and directed bench for forget_gate_mac with an arithmetic reference model and
// a queue-based scoreboard popped by an independent output monitor.
module tb_forget_gate_mac;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready, busy, out_valid, out_ready;
  logic [7:0] bias, x_data, w_data, z_value;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] xs [4];
  logic [7:0] ws [4];

  forget_gate_mac #(.N_INPUTS(4), .DATA_W(8), .FRAC_W(4), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x_data(x_data), .w_data(w_data),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .z_value(z_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: real-valued Q4.4 sum, round half up, clamp to the signed 8-bit range.
  function automatic logic [7:0] model(input logic [7:0] b);
    int acc;
    int r;
    acc = $signed(b) * 16;
    for (int i = 0; i < 4; i++) acc += $signed(xs[i]) * $signed(ws[i]);
    r = (acc + 8) >>> 4;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got z=0x%0h with no expected result queued", z_value);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        n_cmp--;
        check("sb_z", 32'(z_value), 32'(e));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_beat(input int i, input int gap);
    int n;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    x_data   = xs[i];
    w_data   = ws[i];
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    x_data   = 8'($urandom);
    w_data   = 8'($urandom);
  endtask

  task automatic run_eval(input logic [7:0] b, input int gap, input int hold);
    logic [7:0] e;
    int n;
    e = model(b);
    out_ready = (hold == 0);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = 8'($urandom);
    for (int i = 0; i < 4; i++) feed_beat(i, gap);
    exp_q.push_back(e);
    check("lat_round_valid", 32'(out_valid), 32'd0);
    check("lat_round_busy", 32'(busy), 32'd1);
    tick();
    check("lat_out_valid", 32'(out_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_z", 32'(z_value), 32'(e));
      start = h[0];
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("idle_timeout", 32'(busy), 32'd0);
    if (hold > 0) begin
      tick();
      check("start_ignored", 32'(busy), 32'd0);
    end
    check("z_after_hs", 32'(z_value), 32'(e));
  endtask

  task automatic set_pairs(input logic [7:0] x0, x1, x2, x3, w0, w1, w2, w3);
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
    x_data = '0; w_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_z", 32'(z_value), 32'd0);

    set_pairs(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
    run_eval(8'h00, 0, 0);
    check("unit_sum", 32'(z_value), 32'h40);
    run_eval(8'h00, 3, 0);
    check("unit_sum_gaps", 32'(z_value), 32'h40);

    set_pairs(8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h12, 8'h7F, 8'h80);
    run_eval(8'h10, 0, 0);
    check("bias_pos", 32'(z_value), 32'h10);
    run_eval(8'hF0, 1, 0);
    check("bias_neg", 32'(z_value), 32'hF0);

    set_pairs(8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
    run_eval(8'h00, 0, 0);
    check("round_half", 32'(z_value), 32'h01);
    ws[0] = 8'h07;
    run_eval(8'h00, 0, 0);
    check("round_below", 32'(z_value), 32'h00);

    set_pairs(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run_eval(8'h00, 0, 0);
    check("sat_pos", 32'(z_value), 32'h7F);
    set_pairs(8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run_eval(8'h00, 0, 10);
    check("sat_neg_bp", 32'(z_value), 32'h80);

    // Abort mid-evaluation; the partial sum must not leak into the next result.
    set_pairs(8'h7F, 8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h00, 8'h00);
    start = 1'b1; bias = 8'h20;
    tick();
    start = 1'b0;
    feed_beat(0, 0);
    feed_beat(1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("mid_rst_no_out", 32'(out_valid), 32'd0);
      tick();
    end
    set_pairs(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
    run_eval(8'h00, 0, 0);
    check("after_rst_result", 32'(z_value), 32'h40);

    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    tick();
    check("rst_start_idle", 32'(busy), 32'd0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = 8'($urandom);
        ws[i] = 8'($urandom);
      end
      run_eval(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)) * int'($urandom_range(1, 4)));
    end

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
